alu_mc: RTL and testbench

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_core.sv | 43 ++++
 rtl/alu_mc.sv | 106 ++++++++++
 tb/tb_alu_mc.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode and FSM state encodings for the multi-cycle ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_ADDC = 4'd1,
    OP_SUB  = 4'd2,
    OP_SUBC = 4'd3,
    OP_CMP  = 4'd4,
    OP_AND  = 4'd5,
    OP_OR   = 4'd6,
    OP_XOR  = 4'd7,
    OP_TEST = 4'd8,
    OP_LSL  = 4'd9,
    OP_LSR  = 4'd10,
    OP_ROL  = 4'd11,
    OP_ROR  = 4'd12,
    OP_ASR  = 4'd13,
    OP_MOV  = 4'd14,
    OP_MUL  = 4'd15
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_FIN  = 2'd3
  } alu_state_t;

endpackage

// File: rtl/alu_core.sv
// Single-cycle ALU datapath: combinational, returns {carry, result}.
// Arithmetic is done WIDTH+1 bits wide so the top bit is carry (add) or borrow (subtract).
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  alu_op_t          sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH:0]   cr
);

  logic [WIDTH:0] ax;
  logic [WIDTH:0] bx;
  logic [WIDTH:0] cx;

  assign ax = {1'b0, a};
  assign bx = {1'b0, b};
  assign cx = {{WIDTH{1'b0}}, cin};

  always_comb begin
    cr = '0;
    case (sel)
      OP_ADD:         cr = ax + bx;
      OP_ADDC:        cr = ax + bx + cx;
      OP_SUB, OP_CMP: cr = ax - bx;
      OP_SUBC:        cr = ax - bx - cx;
      OP_AND, OP_TEST: cr = {1'b0, a & b};
      OP_OR:          cr = {1'b0, a | b};
      OP_XOR:         cr = {1'b0, a ^ b};
      OP_LSL:         cr = {a[WIDTH-1], a[WIDTH-2:0], cin};
      OP_LSR:         cr = {a[0], cin, a[WIDTH-1:1]};
      OP_ROL:         cr = {a[WIDTH-1], a[WIDTH-2:0], a[WIDTH-1]};
      OP_ROR:         cr = {a[0], a[0], a[WIDTH-1:1]};
      OP_ASR:         cr = {a[0], a[WIDTH-1], a[WIDTH-1:1]};
      OP_MOV:         cr = {cin, b};
      default:        cr = '0;
    endcase
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ops via alu_core, unsigned MUL via iterative shift-add.
//   state | meaning
//   IDLE  | waiting for START; operands captured on acceptance
//   EXEC  | single-cycle op evaluated, flags registered on exit
//   MUL   | WIDTH shift-add iterations, then one terminal-count cycle
//   FIN   | DONE pulse; START here is ignored
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [3:0]       SEL,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic             C,
  output logic             Z
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

  alu_state_t         state;
  alu_state_t         state_nx;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               cin_q;
  alu_op_t            sel_q;
  logic [2*WIDTH-1:0] prod;
  logic [CW-1:0]      cnt;
  logic [WIDTH:0]     core_cr;
  logic [WIDTH:0]     mul_sum;
  logic               accept;

  assign accept = START && (state == ST_IDLE);
  assign BUSY   = (state != ST_IDLE);
  assign DONE   = (state == ST_FIN);

  alu_core #(.WIDTH(WIDTH)) u_core (
    .sel (sel_q),
    .a   (a_q),
    .b   (b_q),
    .cin (cin_q),
    .cr  (core_cr)
  );

  // High half plus multiplicand when the current multiplier LSB is set.
  assign mul_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, a_q} : '0);

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (START) state_nx = (alu_op_t'(SEL) == OP_MUL) ? ST_MUL : ST_EXEC;
      ST_EXEC: state_nx = ST_FIN;
      ST_MUL:  if (cnt == '0) state_nx = ST_FIN;
      ST_FIN:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state  <= ST_IDLE;
      a_q    <= '0;
      b_q    <= '0;
      cin_q  <= 1'b0;
      sel_q  <= OP_ADD;
      prod   <= '0;
      cnt    <= '0;
      RESULT <= '0;
      C      <= 1'b0;
      Z      <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        a_q   <= A;
        b_q   <= B;
        cin_q <= CIN;
        sel_q <= alu_op_t'(SEL);
        prod  <= {{WIDTH{1'b0}}, B};
        cnt   <= CNT_INIT;
      end
      if (state == ST_MUL && cnt != '0) begin
        prod <= {mul_sum, prod[WIDTH-1:1]};
        cnt  <= cnt - CW'(1);
      end
      if (state == ST_EXEC) begin
        RESULT <= core_cr[WIDTH-1:0];
        C      <= core_cr[WIDTH];
        Z      <= (core_cr[WIDTH-1:0] == '0);
      end
      if (state == ST_MUL && cnt == '0) begin
        RESULT <= prod[WIDTH-1:0];
        C      <= |prod[2*WIDTH-1:WIDTH];
        Z      <= (prod == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed corner cases plus random ops against an arithmetic model.
module tb_alu_mc;

  typedef struct packed {
    logic [31:0] r;
    logic        c;
    logic        z;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        START;
  logic [3:0]  SEL;
  logic [7:0]  A;
  logic [7:0]  B;
  logic        CIN;
  logic        BUSY;
  logic        DONE;
  logic [7:0]  RESULT;
  logic        C;
  logic        Z;

  logic        start16;
  logic [3:0]  sel16;
  logic [15:0] a16;
  logic [15:0] b16;
  logic        cin16;
  logic        busy16;
  logic        done16;
  logic [15:0] result16;
  logic        c16;
  logic        z16;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  alu_mc #(.WIDTH(8)) u_dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .SEL(SEL), .A(A), .B(B), .CIN(CIN),
    .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT), .C(C), .Z(Z)
  );

  alu_mc #(.WIDTH(16)) u_dut16 (
    .CLK(CLK), .RST_N(RST_N), .START(start16), .SEL(sel16), .A(a16), .B(b16), .CIN(cin16),
    .BUSY(busy16), .DONE(done16), .RESULT(result16), .C(c16), .Z(z16)
  );

  // Reference behaviour in plain integer arithmetic.
  function automatic exp_t ref_op(input int w, input int sel, input longint a,
                                  input longint b, input longint cin);
    longint mask;
    longint msb;
    longint p;
    exp_t   e;
    mask = (longint'(1) << w) - 1;
    msb  = (a >> (w - 1)) & 1;
    p    = 0;
    e    = '0;
    case (sel)
      0:  begin p = a + b;       e.r = 32'(p & mask); e.c = ((p >> w) & 1) != 0; end
      1:  begin p = a + b + cin; e.r = 32'(p & mask); e.c = ((p >> w) & 1) != 0; end
      2, 4: begin e.r = 32'((a - b) & mask);       e.c = (a < b); end
      3:  begin e.r = 32'((a - b - cin) & mask);    e.c = (a < b + cin); end
      5, 8: e.r = 32'(a & b);
      6:  e.r = 32'(a | b);
      7:  e.r = 32'(a ^ b);
      9:  begin e.r = 32'(((a << 1) | cin) & mask);        e.c = (msb != 0); end
      10: begin e.r = 32'((a >> 1) | (cin << (w - 1)));   e.c = ((a & 1) != 0); end
      11: begin e.r = 32'(((a << 1) | msb) & mask);        e.c = (msb != 0); end
      12: begin e.r = 32'((a >> 1) | ((a & 1) << (w - 1))); e.c = ((a & 1) != 0); end
      13: begin e.r = 32'((a >> 1) | (msb << (w - 1)));    e.c = ((a & 1) != 0); end
      14: begin e.r = 32'(b); e.c = (cin != 0); end
      default: begin p = a * b; e.r = 32'(p & mask); e.c = (p >> w) != 0; end
    endcase
    if (sel == 15) e.z = (p == 0);
    else           e.z = (e.r == 0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one op on the 8-bit DUT; inputs are scrambled after acceptance.
  task automatic do_op(input int sel, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input bit mid_pulse, input string tag);
    exp_t       e;
    int         cyc;
    int         lat;
    logic [7:0] held_r;
    bit         held_ok;
    e   = ref_op(8, sel, longint'(a), longint'(b), longint'(cin));
    lat = (sel == 15) ? 10 : 2;
    @(negedge CLK);
    START = 1'b1; SEL = 4'(sel); A = a; B = b; CIN = cin;
    held_r  = RESULT;
    held_ok = 1'b1;
    @(negedge CLK);
    START = 1'b0; SEL = 4'($urandom); A = 8'($urandom); B = 8'($urandom); CIN = 1'($urandom);
    cyc = 1;
    while (!DONE && cyc < 40) begin
      if (RESULT !== held_r || BUSY !== 1'b1) held_ok = 1'b0;
      START = mid_pulse && (cyc == 4);
      @(negedge CLK);
      cyc++;
    end
    START = 1'b0;
    chk({tag, " held"},    32'(held_ok), 32'd1);
    chk({tag, " latency"}, 32'(cyc), 32'(lat));
    chk({tag, " result"},  32'(RESULT), e.r);
    chk({tag, " c"},       32'(C), 32'(e.c));
    chk({tag, " z"},       32'(Z), 32'(e.z));
  endtask

  task automatic do_op16(input int sel, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input string tag);
    exp_t e;
    int   cyc;
    int   lat;
    e   = ref_op(16, sel, longint'(a), longint'(b), longint'(cin));
    lat = (sel == 15) ? 18 : 2;
    @(negedge CLK);
    start16 = 1'b1; sel16 = 4'(sel); a16 = a; b16 = b; cin16 = cin;
    @(negedge CLK);
    start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
    cyc = 1;
    while (!done16 && cyc < 60) begin
      @(negedge CLK);
      cyc++;
    end
    chk({tag, " latency"}, 32'(cyc), 32'(lat));
    chk({tag, " result"},  32'(result16), e.r);
    chk({tag, " c"},       32'(c16), 32'(e.c));
    chk({tag, " z"},       32'(z16), 32'(e.z));
  endtask

  initial begin
    int ndone;
    RST_N = 1'b0; START = 1'b0; SEL = '0; A = '0; B = '0; CIN = 1'b0;
    start16 = 1'b0; sel16 = '0; a16 = '0; b16 = '0; cin16 = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst busy", 32'(BUSY), 32'd0);
    chk("rst done", 32'(DONE), 32'd0);
    chk("rst result", 32'(RESULT), 32'd0);
    chk("rst c", 32'(C), 32'd0);
    chk("rst z", 32'(Z), 32'd0);
    chk("rst16 busy", 32'(busy16), 32'd0);
    chk("rst16 result", 32'(result16), 32'd0);
    RST_N = 1'b1;

    do_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, "add ff+01");
    do_op(3, 8'h10, 8'h10, 1'b1, 1'b0, "subc 10-10-1");
    do_op(13, 8'h81, 8'h00, 1'b0, 1'b0, "asr 81");
    do_op(15, 8'h10, 8'h10, 1'b0, 1'b1, "mul 10x10");
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge CLK);
      if (DONE) ndone++;
    end
    chk("mul no second done", 32'(ndone), 32'd0);

    @(negedge CLK);
    START = 1'b1; SEL = 4'd14; A = 8'h00; B = 8'h5A; CIN = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge CLK);
      chk($sformatf("b2b done %0d", i), 32'(DONE), 32'((i % 3) == 2));
      if ((i % 3) == 2) begin
        chk($sformatf("b2b result %0d", i), 32'(RESULT), 32'h5A);
        chk($sformatf("b2b c %0d", i), 32'(C), 32'd1);
      end
    end
    START = 1'b0;

    do_op(14, 8'h00, 8'h33, 1'b1, 1'b0, "mov 33");
    START = 1'b1; SEL = 4'd0;
    @(negedge CLK);
    START = 1'b0;
    chk("fin start ignored", 32'(BUSY), 32'd0);
    @(negedge CLK);
    chk("fin start ignored 2", 32'(BUSY), 32'd0);

    @(negedge CLK);
    START = 1'b1; SEL = 4'd15; A = 8'h03; B = 8'h05; CIN = 1'b0;
    @(negedge CLK);
    START = 1'b0;
    repeat (3) @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    chk("abort busy", 32'(BUSY), 32'd0);
    chk("abort done", 32'(DONE), 32'd0);
    chk("abort result", 32'(RESULT), 32'd0);
    chk("abort c", 32'(C), 32'd0);
    chk("abort z", 32'(Z), 32'd0);
    RST_N = 1'b1;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge CLK);
      if (DONE) ndone++;
    end
    chk("abort no done", 32'(ndone), 32'd0);
    do_op(0, 8'h02, 8'h03, 1'b0, 1'b0, "add after rst");

    for (int i = 0; i < 30; i++) begin
      int s;
      s = int'($urandom_range(0, 15));
      do_op(s, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0, $sformatf("rnd%0d sel%0d", i, s));
    end
    do_op(15, 8'h00, 8'($urandom), 1'b0, 1'b0, "mul zero");

    do_op16(1, 16'hFFFF, 16'h0000, 1'b1, "w16 addc");
    do_op16(15, 16'h1234, 16'h00F1, 1'b0, "w16 mul");
    do_op16(15, 16'($urandom), 16'($urandom), 1'b0, "w16 mul rnd");
    do_op16(10, 16'h8001, 16'h0000, 1'b1, "w16 lsr");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
